// File: rtl/keypad_pkg.sv
// Shared types and helpers for the safe keypad input stage.
// Consumed by keypad_debounce and its synchroniser.
package keypad_pkg;

    localparam int KEY_COUNT = 10;

    typedef enum logic [2:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT,
        REJECT
    } kp_state_t;

    function automatic logic [3:0] onehot_to_code(
        input logic [KEY_COUNT-1:0] v
    );
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < KEY_COUNT; i++) begin
            if (v[i]) c = 4'(i);
        end
        return c;
    endfunction

    function automatic logic is_onehot(
        input logic [KEY_COUNT-1:0] v
    );
        return $countones(v) == 1;
    endfunction

endpackage

// File: rtl/keypad_debounce_sync.sv
// Parameterised-width two-flop synchroniser, async active-high reset.
// Module key_sync; one instance covers every keypad line.
module key_sync #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_debounce.sv
// Keypad debounce, chord rejection and press/release pulse generation.
// Optional auto-repeat while held: define KEYPAD_REPEAT_EN.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int REPEAT_DELAY    = 500,
    parameter int REPEAT_PERIOD   = 100
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [KEY_COUNT-1:0] keys_raw,
    output logic                 key_valid,
    output logic [3:0]           key_code,
    output logic                 key_press,
    output logic                 key_release,
    output logic                 multi_err
);

    localparam int CMAX1 = (DEBOUNCE_CYCLES > REPEAT_DELAY) ?
                           DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int CMAX  = (CMAX1 > REPEAT_PERIOD) ? CMAX1 : REPEAT_PERIOD;
    localparam int CW    = $clog2(CMAX + 1);
    localparam logic [CW-1:0] DLIM = CW'(DEBOUNCE_CYCLES - 1);

    logic [KEY_COUNT-1:0] sync;
    logic [KEY_COUNT-1:0] cap, cap_n;
    logic [CW-1:0]        cnt, cnt_n;
    kp_state_t            state, state_n;
    logic                 valid_n, press_n, rel_n, err_n;
    logic [3:0]           code_n;

    key_sync #(.W(KEY_COUNT)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (keys_raw),
        .q   (sync)
    );

`ifdef KEYPAD_REPEAT_EN
    logic [CW-1:0] rcnt, rcnt_n;
    logic          rfirst, rfirst_n;
    logic [CW-1:0] rlim;

    // First repeat waits the long delay, later ones the short period.
    assign rlim = rfirst ? CW'(REPEAT_DELAY - 1) : CW'(REPEAT_PERIOD - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rcnt   <= '0;
            rfirst <= 1'b1;
        end else begin
            rcnt   <= rcnt_n;
            rfirst <= rfirst_n;
        end
    end
`endif

    always_comb begin
        state_n = state;
        cap_n   = cap;
        cnt_n   = cnt;
        valid_n = key_valid;
        code_n  = key_code;
        press_n = 1'b0;
        rel_n   = 1'b0;
        err_n   = multi_err;
`ifdef KEYPAD_REPEAT_EN
        rcnt_n   = '0;
        rfirst_n = 1'b1;
`endif
        unique case (state)
            IDLE: begin
                if (sync != '0) begin
                    cap_n   = sync;
                    cnt_n   = '0;
                    state_n = PRESS_WAIT;
                end
            end
            PRESS_WAIT: begin
                if (sync != cap) begin
                    state_n = IDLE;
                end else if (cnt == DLIM) begin
                    if (is_onehot(cap)) begin
                        state_n = HELD;
                        code_n  = onehot_to_code(cap);
                        valid_n = 1'b1;
                        press_n = 1'b1;
                    end else begin
                        state_n = REJECT;
                        err_n   = 1'b1;
                        cnt_n   = '0;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            HELD: begin
                if (sync != cap) begin
                    state_n = RELEASE_WAIT;
                    cnt_n   = '0;
                end else begin
`ifdef KEYPAD_REPEAT_EN
                    if (rcnt == rlim) begin
                        press_n  = 1'b1;
                        rfirst_n = 1'b0;
                    end else begin
                        rcnt_n   = rcnt + CW'(1);
                        rfirst_n = rfirst;
                    end
`endif
                end
            end
            RELEASE_WAIT: begin
                if (sync == cap) begin
                    state_n = HELD;
                end else if (sync != '0) begin
                    cnt_n = '0;
                end else if (cnt == DLIM) begin
                    state_n = IDLE;
                    valid_n = 1'b0;
                    rel_n   = 1'b1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            REJECT: begin
                if (sync != '0) begin
                    cnt_n = '0;
                end else if (cnt == DLIM) begin
                    state_n = IDLE;
                    err_n   = 1'b0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cap         <= '0;
            cnt         <= '0;
            key_valid   <= 1'b0;
            key_code    <= 4'd0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            multi_err   <= 1'b0;
        end else begin
            state       <= state_n;
            cap         <= cap_n;
            cnt         <= cnt_n;
            key_valid   <= valid_n;
            key_code    <= code_n;
            key_press   <= press_n;
            key_release <= rel_n;
            multi_err   <= err_n;
        end
    end

endmodule

// File: tb/tb_keypad_debounce.sv
// Bench for keypad_debounce: vector table, corner sequences, random vs model.
module tb_keypad_debounce;

    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 5;
`ifdef KEYPAD_REPEAT_EN
    localparam int REP = 1;
`else
    localparam int REP = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] keys_raw = '0;
    logic       key_valid, key_press, key_release, multi_err;
    logic [3:0] key_code;
    logic [7:0] outs;

    int passed = 0;
    int total  = 0;
    int npress = 0;
    int nrel   = 0;
    int nlow   = 0;

    // Reference model state
    int         mmode, mrun, mzr, mhc;
    logic [9:0] mprev, mc, mlast, d1, d2;
    int         ev, ec, ep, er, ee;

    typedef struct {
        logic [9:0] raw;
        int         n;
        int         exp;
    } vec_t;
    vec_t tbl[15];

    always #5 clk = ~clk;

    assign outs = {key_valid, key_code, key_press, key_release, multi_err};

    keypad_debounce #(
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .keys_raw    (keys_raw),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .key_press   (key_press),
        .key_release (key_release),
        .multi_err   (multi_err)
    );

    function automatic int pk(input int v, input int c, input int p,
                              input int r, input int e);
        return (v << 7) | ((c & 15) << 3) | (p << 2) | (r << 1) | e;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            npress += int'(key_press);
            nrel   += int'(key_release);
            if (!key_valid) nlow++;
        end
    endtask

    // Sample-level model: a press needs D+1 equal samples from idle; a
    // release needs D+1 zero samples straight after the key, or D after
    // any other non-zero sample; a chord clears after D zero samples.
    task automatic mstep(input logic [9:0] s);
        int need;
        int idx;
        ep = 0;
        er = 0;
        mrun = (s == mprev) ? mrun + 1 : 1;
        idx = 0;
        for (int i = 0; i < 10; i++) if (s[i]) idx = i;
        case (mmode)
            0: if (s != 0 && mrun == D + 1) begin
                if ($countones(s) == 1) begin
                    mmode = 1; mc = s; ev = 1; ec = idx; ep = 1; mhc = 0;
                end else begin
                    mmode = 2; ee = 1;
                end
            end
            1: if (s == mc) begin
                if (mprev == mc) begin
                    mhc++;
                    if (REP == 1 && mhc >= RD && (mhc - RD) % RP == 0)
                        ep = 1;
                end else begin
                    mhc = 0;
                end
            end else if (s == 0) begin
                need = (mlast == mc) ? D + 1 : D;
                if (mzr + 1 == need) begin
                    mmode = 0; ev = 0; er = 1;
                end
            end
            default: if (s == 0 && mzr + 1 == D) begin
                mmode = 0; ee = 0;
            end
        endcase
        mzr = (s == 0) ? mzr + 1 : 0;
        if (s != 0) mlast = s;
        mprev = s;
    endtask

    function automatic logic [9:0] rnd_nz(input logic [9:0] last);
        logic [9:0] v;
        if ($urandom_range(0, 9) < 6) begin
            if (last != 0 && $countones(last) == 1 && $urandom_range(0, 2) == 0)
                return last;
            v = 10'd1 << $urandom_range(0, 9);
        end else begin
            v = 10'($urandom_range(1, 1023));
            while ($countones(v) < 2) v = 10'($urandom_range(1, 1023));
        end
        return v;
    endfunction

    initial begin
        logic [9:0] val;
        logic [9:0] lastnz;
        int         len;

        #1;
        chk("reset_async", int'(outs), 0);
        tick(2);
        chk("reset_hold", int'(outs), 0);
        rst = 1'b0;

        tbl[0]  = '{10'h000, 3,  pk(0, 0, 0, 0, 0)};
        tbl[1]  = '{10'h008, 6,  pk(0, 0, 0, 0, 0)};
        tbl[2]  = '{10'h008, 1,  pk(1, 3, 1, 0, 0)};
        tbl[3]  = '{10'h008, 1,  pk(1, 3, 0, 0, 0)};
        tbl[4]  = '{10'h008, 10, pk(1, 3, 0, 0, 0)};
        tbl[5]  = '{10'h000, 6,  pk(1, 3, 0, 0, 0)};
        tbl[6]  = '{10'h000, 1,  pk(0, 3, 0, 1, 0)};
        tbl[7]  = '{10'h000, 1,  pk(0, 3, 0, 0, 0)};
        tbl[8]  = '{10'h082, 6,  pk(0, 3, 0, 0, 0)};
        tbl[9]  = '{10'h082, 1,  pk(0, 3, 0, 0, 1)};
        tbl[10] = '{10'h082, 8,  pk(0, 3, 0, 0, 1)};
        tbl[11] = '{10'h000, 5,  pk(0, 3, 0, 0, 1)};
        tbl[12] = '{10'h000, 2,  pk(0, 3, 0, 0, 0)};
        tbl[13] = '{10'h040, 3,  pk(0, 3, 0, 0, 0)};
        tbl[14] = '{10'h000, 8,  pk(0, 3, 0, 0, 0)};

        for (int i = 0; i < 15; i++) begin
            if (i == 13) begin
                npress = 0;
                nrel   = 0;
            end
            keys_raw = tbl[i].raw;
            tick(tbl[i].n);
            chk($sformatf("vec%0d", i), int'(outs), tbl[i].exp);
        end
        chk("glitch_pulses", npress + nrel, 0);

        // Press bounce on key 5
        npress = 0;
        nrel   = 0;
        for (int t = 0; t < 4; t++) begin
            keys_raw = (t % 2 == 0) ? 10'h020 : 10'h000;
            tick(2);
        end
        keys_raw = 10'h020;
        tick(6);
        chk("bounce_early", npress, 0);
        tick(1);
        chk("bounce_press", int'(outs), pk(1, 5, 1, 0, 0));
        tick(6);
        chk("bounce_count", npress, 1);
        keys_raw = '0;
        tick(8);
        chk("bounce_release", nrel, 1);

        // Release bounce on key 2
        keys_raw = 10'h004;
        tick(7);
        chk("rb_press", int'(outs), pk(1, 2, 1, 0, 0));
        npress = 0;
        nrel   = 0;
        nlow   = 0;
        tick(3);
        keys_raw = '0;
        tick(2);
        keys_raw = 10'h004;
        tick(8);
        chk("rb_no_release", nrel, 0);
        chk("rb_no_press", npress, 0);
        chk("rb_valid_low", nlow, 0);
        keys_raw = '0;
        tick(8);
        chk("rb_final_release", nrel, 1);
        chk("rb_idle", int'(outs), pk(0, 2, 0, 0, 0));

        // Reset while a key is held
        keys_raw = 10'h010;
        tick(9);
        chk("rst_pre", int'(outs), pk(1, 4, 0, 0, 0));
        nrel = 0;
        rst  = 1'b1;
        #1;
        chk("rst_immediate", int'(outs), 0);
        tick(2);
        chk("rst_no_release", nrel, 0);
        rst    = 1'b0;
        npress = 0;
        tick(6);
        chk("rst_wait", npress, 0);
        tick(1);
        chk("rst_repress", int'(outs), pk(1, 4, 1, 0, 0));
        keys_raw = '0;
        tick(8);

        // Auto-repeat on key 9
        npress   = 0;
        keys_raw = 10'h200;
        tick(7);
        chk("rep_accept", int'(outs), pk(1, 9, 1, 0, 0));
        tick(30);
        chk("rep_count", npress, (REP == 1) ? 6 : 1);
        keys_raw = '0;
        tick(8);

        // Random segments separated by zero gaps, against the model
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        mmode = 0; mrun = 0; mzr = 0; mhc = 0;
        mprev = '0; mc = '0; mlast = '0; d1 = '0; d2 = '0;
        ev = 0; ec = 0; ep = 0; er = 0; ee = 0;
        lastnz = '0;
        for (int seg = 0; seg < 240; seg++) begin
            if (seg % 2 == 0) begin
                val = '0;
                len = $urandom_range(1, 8);
            end else begin
                val    = rnd_nz(lastnz);
                lastnz = val;
                len    = $urandom_range(1, ($urandom_range(0, 4) == 0) ? 30 : 8);
            end
            for (int c = 0; c < len; c++) begin
                keys_raw = val;
                @(posedge clk);
                #1;
                mstep(d2);
                chk($sformatf("rand_seg%0d", seg), int'(outs),
                    pk(ev, ec, ep, er, ee));
                d2 = d1;
                d1 = val;
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/keypad_debounce.md
# keypad_debounce

Upstream input stage for the digital safe. It synchronises and debounces the raw 10-line one-hot keypad and converts it into a clean held-key level, a 4-bit key code, and single-cycle press/release pulses. Multi-key chords are rejected. The safe's entry FSM consumes `key_press`/`key_code` instead of sampling the raw keypad.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 20: cycles a sampled vector must stay stable before acceptance; legal minimum 2.
- `REPEAT_DELAY`, default 500: cycles of continuous hold before the first auto-repeat pulse. Used only with the repeat macro.
- `REPEAT_PERIOD`, default 100: cycles between subsequent auto-repeat pulses. Used only with the repeat macro.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `keys_raw` in 10: raw keypad lines; bit n high means key n pressed; asynchronous to `clk`.
- `key_valid` out 1: level, high while a debounced single key is held.
- `key_code` out 4: binary index 0–9 of the held key; holds its last value after release.
- `key_press` out 1: one-cycle pulse when a key is accepted, and on each auto-repeat.
- `key_release` out 1: one-cycle pulse when a held key's release is accepted.
- `multi_err` out 1: level, high while a debounced multi-key vector is being rejected.

## Operation
- Input path: 2-flop synchroniser on all 10 lines, giving `sync`. The FSM uses only `sync`.
- Counter `cnt` is wide enough for `max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)`. The captured vector is `cap[9:0]`.
- States: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT, REJECT.
- **IDLE**
  - If `sync != 0`: set `cap <= sync`, `cnt <= 0`, go to PRESS_WAIT.
- **PRESS_WAIT**
  - If `sync != cap`: go to IDLE (bounce, discarded).
  - Else if `cnt == DEBOUNCE_CYCLES-1`:
    - If `cap` is one-hot: go to HELD; `key_code <= index(cap)`, `key_valid <= 1`, pulse `key_press`.
    - If `cap` is not one-hot: go to REJECT; `multi_err <= 1`; `cnt <= 0`.
  - Else `cnt++`.
- **HELD**
  - If `sync != cap`: go to RELEASE_WAIT, `cnt <= 0`. `key_valid` stays high.
- **RELEASE_WAIT**
  - If `sync == cap`: return to HELD; no pulse.
  - Else if `sync != 0`: `cnt <= 0`. A full release is required; a different key cannot take over directly.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: go to IDLE; `key_valid <= 0`, pulse `key_release`.
  - Else `cnt++`.
- **REJECT**
  - Same counting as RELEASE_WAIT, except there is no return-to-HELD path.
  - On completion: go to IDLE, `multi_err <= 0`, no pulses.
- All outputs are registered. `key_press` and `key_release` are never high in the same cycle.
- Reset values: state IDLE; `cap`, `cnt`, sync flops = 0; `key_valid`=0, `key_code`=4'd0, `key_press`=0, `key_release`=0, `multi_err`=0.
- Reset asserted mid-operation (any state): all outputs go to their reset values immediately. No release pulse is issued.

## Timing
- Let `keys_raw` change before edge k and then stay stable. IDLE sees the new value at edge k+2.
- Press: `key_press` and `key_valid` go high after edge k+2+DEBOUNCE_CYCLES. The pulse is exactly 1 cycle.
- Release: symmetric; `key_release` goes high after edge k+2+DEBOUNCE_CYCLES, measured from the last raw change to zero.
- A glitch shorter than DEBOUNCE_CYCLES+1 cycles produces no output activity.

## Configuration
- `KEYPAD_REPEAT_EN` defined:
  - In HELD, a repeat counter starts at 0 on entry.
  - The first extra `key_press` pulse comes REPEAT_DELAY cycles after the accept pulse.
  - Further pulses follow every REPEAT_PERIOD cycles.
  - The counter resets on leaving HELD. Returning to HELD from RELEASE_WAIT resumes repeat timing from 0.
- `KEYPAD_REPEAT_EN` undefined: exactly one `key_press` per hold. The repeat parameters are ignored and no repeat logic is synthesised.

## Structure
- Shared package `keypad_pkg` contains:
  - `kp_state_t` enum for the five states;
  - `KEY_COUNT = 10`;
  - function `onehot_to_code` (10-bit to 4-bit);
  - function `is_onehot`.
- Sub-module `key_sync`: parameterised-width 2-flop synchroniser with async reset. It is instantiated once for `keys_raw`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4` and drive `keys_raw` at the same edge offsets.
- **Clean press/release:** key 3 held 20 cycles → one `key_press` after edge k+6, `key_code`=3, `key_valid` high. Release → one `key_release` 6 cycles after release.
- **Press bounce:** key 5 toggled every 2 cycles for 10 cycles, then stable → exactly one `key_press`, 6 cycles after the last toggle; `key_code`=5.
- **Release bounce:** key 2 held, then dropped for 2 cycles and restored → no `key_release`, no second `key_press`, `key_valid` stays high.
- **Multi-key:** keys 1 and 7 together for 15 cycles → `multi_err` high from edge k+6, no `key_press`, `key_valid`=0. `multi_err` clears 6 cycles after all keys are released.
- **Reset during HELD:** assert `rst` → all outputs 0 immediately, no `key_release`. After deassert with the key still held → a fresh `key_press` after 6 cycles.
- **Auto-repeat:** `KEYPAD_REPEAT_EN` defined, REPEAT_DELAY=10, REPEAT_PERIOD=5, key 9 held 30 cycles after accept → `key_press` pulses at accept+0, +10, +15, +20, +25, +30 (6 pulses). With the macro undefined → 1 pulse.
